// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the program-flash arbiter.
// Covers the owner tag, byte-select codes, wait-counter width and a byte-lane helper.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic BSEL_LO = 1'b0;
    localparam logic BSEL_HI = 1'b1;

    localparam int unsigned WAIT_W = 4;

    function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic sel);
        return (sel == BSEL_HI) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/flash_arb_if.sv
// Requester-side bundle of the flash arbiter: fetch port I and byte-read port D.
// The slave modport belongs to the arbiter and the master modport to the requesters.
interface flash_arb_if #(
    parameter int unsigned FLASH_WIDTH = 10
);
    logic                   i_req;
    logic [FLASH_WIDTH-1:0] i_addr;
    logic                   i_gnt;
    logic                   i_valid;
    logic [15:0]            i_data;
    logic                   d_req;
    logic [FLASH_WIDTH:0]   d_addr;
    logic                   d_gnt;
    logic                   d_valid;
    logic [7:0]             d_data;

    modport slave (
        input  i_req, i_addr, d_req, d_addr,
        output i_gnt, i_valid, i_data, d_gnt, d_valid, d_data
    );

    modport master (
        output i_req, i_addr, d_req, d_addr,
        input  i_gnt, i_valid, i_data, d_gnt, d_valid, d_data
    );
endinterface

// File: rtl/flash_arb_sel.sv
// Grant logic for the flash arbiter.
// Fixed I priority with a D starvation counter, or round-robin when FLASH_ARB_RR_EN is defined.
module flash_arb_sel
    import flash_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic d_req,
    output logic i_gnt,
    output logic d_gnt
);

`ifdef FLASH_ARB_RR_EN
    logic last_d_q;
    logic last_d_d;

    // Grant decision: on contention the port granted last loses.
    always_comb begin
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        last_d_d = last_d_q;
        if (!rst_n) begin
            i_gnt = 1'b0;
            d_gnt = 1'b0;
        end else if (i_req && d_req) begin
            i_gnt = last_d_q;
            d_gnt = !last_d_q;
        end else begin
            i_gnt = i_req;
            d_gnt = d_req;
        end
        if (i_gnt) begin
            last_d_d = 1'b0;
        end else if (d_gnt) begin
            last_d_d = 1'b1;
        end else begin
            last_d_d = last_d_q;
        end
    end

    // Last-granted pointer; starts at D so the first contended cycle goes to I.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b1;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT   = {WAIT_W{1'b1}};

    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;

    // Grant decision plus saturating count of consecutive D denials.
    always_comb begin
        i_gnt  = 1'b0;
        d_gnt  = 1'b0;
        wait_d = {WAIT_W{1'b0}};
        if (!rst_n) begin
            i_gnt = 1'b0;
            d_gnt = 1'b0;
        end else if (d_req && (wait_q >= MAX_WAIT_C)) begin
            d_gnt = 1'b1;
        end else if (i_req) begin
            i_gnt = 1'b1;
        end else begin
            d_gnt = d_req;
        end
        if (d_req && !d_gnt) begin
            wait_d = (wait_q == WAIT_SAT) ? wait_q : wait_q + 4'd1;
        end else begin
            wait_d = {WAIT_W{1'b0}};
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= {WAIT_W{1'b0}};
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

endmodule

// File: rtl/flash_arbiter.sv
// Shares a 1-cycle-latency program flash between fetch port I and byte-read port D.
// Optional round-robin priority is selected with the FLASH_ARB_RR_EN macro.
module flash_arbiter
    import flash_arb_pkg::*;
#(
    parameter int unsigned FLASH_WIDTH = 10,
    parameter int unsigned MAX_WAIT    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    flash_arb_if.slave             bus,
    output logic                   mem_ce,
    output logic [FLASH_WIDTH-1:0] mem_a,
    input  logic [15:0]            mem_d
);

    logic   i_gnt_s;
    logic   d_gnt_s;
    owner_e owner_q, owner_d;
    logic   bsel_q, bsel_d;
    logic [15:0] i_hold_q, i_hold_d;
    logic [7:0]  d_hold_q, d_hold_d;

    flash_arb_sel #(
        .MAX_WAIT (MAX_WAIT)
    ) u_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (bus.i_req),
        .d_req (bus.d_req),
        .i_gnt (i_gnt_s),
        .d_gnt (d_gnt_s)
    );

    assign bus.i_gnt = i_gnt_s;
    assign bus.d_gnt = d_gnt_s;
    assign mem_ce    = i_gnt_s | d_gnt_s;

    // Flash address follows whichever port holds the grant.
    always_comb begin
        mem_a = {FLASH_WIDTH{1'b0}};
        if (i_gnt_s) begin
            mem_a = bus.i_addr;
        end else if (d_gnt_s) begin
            mem_a = bus.d_addr[FLASH_WIDTH:1];
        end else begin
            mem_a = {FLASH_WIDTH{1'b0}};
        end
    end

    // Issue tag for next cycle and return-data capture for the current owner.
    // The return word is passed straight through while it arrives so data and valid coincide.
    always_comb begin
        owner_d  = OWN_NONE;
        bsel_d   = bsel_q;
        i_hold_d = i_hold_q;
        d_hold_d = d_hold_q;
        if (i_gnt_s) begin
            owner_d = OWN_I;
        end else if (d_gnt_s) begin
            owner_d = OWN_D;
            bsel_d  = bus.d_addr[0];
        end else begin
            owner_d = OWN_NONE;
        end
        case (owner_q)
            OWN_I:   i_hold_d = mem_d;
            OWN_D:   d_hold_d = byte_sel(mem_d, bsel_q);
            default: begin
                i_hold_d = i_hold_q;
                d_hold_d = d_hold_q;
            end
        endcase
    end

    // Return-path state; reset discards any access still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= OWN_NONE;
            bsel_q   <= BSEL_LO;
            i_hold_q <= 16'h0000;
            d_hold_q <= 8'h00;
        end else begin
            owner_q  <= owner_d;
            bsel_q   <= bsel_d;
            i_hold_q <= i_hold_d;
            d_hold_q <= d_hold_d;
        end
    end

    assign bus.i_valid = (owner_q == OWN_I);
    assign bus.d_valid = (owner_q == OWN_D);
    assign bus.i_data  = i_hold_d;
    assign bus.d_data  = d_hold_d;

endmodule

// File: tb/tb_flash_arbiter.sv
// Self-checking bench for flash_arbiter: flash model, scoreboard of expected returns,
// directed reset / fetch / byte-read / starvation / back-to-back / mid-op reset sequences.
module tb_flash_arbiter;

    localparam int unsigned FW = 10;

    logic          clk;
    logic          rst_n;
    logic          mem_ce;
    logic [FW-1:0] mem_a;
    logic [15:0]   mem_d;
    logic [15:0]   flash [0:(1<<FW)-1];

    int n_checks;
    int n_pass;
    int d_vcnt;

    typedef struct {
        bit          is_d;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    flash_arb_if #(.FLASH_WIDTH(FW)) bus ();

    flash_arbiter #(.FLASH_WIDTH(FW), .MAX_WAIT(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .mem_ce (mem_ce),
        .mem_a  (mem_a),
        .mem_d  (mem_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous flash model: read word appears the cycle after chip enable.
    always @(posedge clk) begin
        if (mem_ce) mem_d <= flash[mem_a];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input logic [FW:0] a);
        logic [15:0] w;
        w = flash[a[FW:1]];
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    // Monitor: retire expected returns, then record this cycle's grants.
    always @(negedge clk) begin
        exp_t e;
        logic [FW-1:0] ea;
        if (!rst_n) begin
            chk("rst_outputs", {27'd0, bus.i_gnt, bus.d_gnt, mem_ce, bus.i_valid, bus.d_valid}, 32'd0);
            chk("rst_data", {8'h00, bus.i_data, bus.d_data}, 32'd0);
            sb.delete();
        end else begin
            if (bus.d_valid) d_vcnt++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.is_d) begin
                    chk("d_valid", {30'd0, bus.i_valid, bus.d_valid}, 32'd1);
                    chk("d_data", {24'd0, bus.d_data}, {24'd0, e.data[7:0]});
                end else begin
                    chk("i_valid", {30'd0, bus.i_valid, bus.d_valid}, 32'd2);
                    chk("i_data", {16'd0, bus.i_data}, {16'd0, e.data});
                end
            end else begin
                chk("no_valid", {30'd0, bus.i_valid, bus.d_valid}, 32'd0);
            end
            chk("one_gnt", {31'd0, bus.i_gnt & bus.d_gnt}, 32'd0);
            ea = bus.i_gnt ? bus.i_addr : (bus.d_gnt ? bus.d_addr[FW:1] : {FW{1'b0}});
            chk("mem_ce", {31'd0, mem_ce}, {31'd0, bus.i_gnt | bus.d_gnt});
            chk("mem_a", {22'd0, mem_a}, {22'd0, ea});
            if (bus.i_gnt) sb.push_back('{1'b0, flash[bus.i_addr]});
            if (bus.d_gnt) sb.push_back('{1'b1, {8'h00, exp_byte(bus.d_addr)}});
        end
    end

    initial begin
        int c0;
        bit exp_d;
        bit gi, gd;
        n_checks = 0;
        n_pass   = 0;
        d_vcnt   = 0;
        mem_d    = 16'h0000;
        for (int k = 0; k < (1 << FW); k++) flash[k] = 16'(k * 16'h3B1D + 16'h1234);
        flash[5]    = 16'hBEEF;
        flash[7]    = 16'hCAFE;
        flash[1023] = 16'h5A3C;

        // 1: reset with both ports requesting
        rst_n      = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 10'h005;
        bus.d_req  = 1'b1;
        bus.d_addr = 11'h00B;
        repeat (3) cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", {30'd0, bus.i_gnt, bus.d_gnt}, 32'd2);
        cyc();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (2) cyc();

        // 2: single fetch
        bus.i_req  = 1'b1;
        bus.i_addr = 10'h005;
        @(negedge clk);
        chk("fetch_gnt", {31'd0, bus.i_gnt}, 32'd1);
        cyc();
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("fetch_data", {15'd0, bus.i_valid, bus.i_data}, {15'd0, 1'b1, 16'hBEEF});
        cyc();

        // 3: byte reads, high then low lane of word 5
        bus.d_req  = 1'b1;
        bus.d_addr = 11'h00B;
        cyc();
        bus.d_addr = 11'h00A;
        @(negedge clk);
        chk("byte_hi", {23'd0, bus.d_valid, bus.d_data}, {23'd0, 1'b1, 8'hBE});
        cyc();
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("byte_lo", {23'd0, bus.d_valid, bus.d_data}, {23'd0, 1'b1, 8'hEF});
        repeat (2) cyc();

        // 4: continuous contention for 50 cycles
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        c0 = d_vcnt;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
`ifdef FLASH_ARB_RR_EN
            exp_d = (k % 2 == 1);
`else
            exp_d = (k % 5 == 4);
`endif
            chk("starve_gnt", {30'd0, bus.i_gnt, bus.d_gnt}, exp_d ? 32'd1 : 32'd2);
            gi = bus.i_gnt;
            gd = bus.d_gnt;
            cyc();
            if (gi) bus.i_addr = 10'($urandom);
            if (gd) bus.d_addr = 11'($urandom);
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        #1;
`ifdef FLASH_ARB_RR_EN
        chk("d_valid_count", 32'(d_vcnt - c0), 32'd25);
`else
        chk("d_valid_count", 32'(d_vcnt - c0), 32'd10);
`endif
        repeat (2) cyc();

        // 5: back-to-back I, D, I including the top word address
        bus.i_req  = 1'b1;
        bus.i_addr = 10'h3FF;
        cyc();
        bus.i_req  = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_addr = 11'h00B;
        @(negedge clk);
        chk("b2b_i0", {15'd0, bus.i_valid, bus.i_data}, {15'd0, 1'b1, 16'h5A3C});
        cyc();
        bus.d_req  = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 10'h007;
        @(negedge clk);
        chk("b2b_d_ihold", {6'd0, bus.d_valid, bus.i_valid, bus.i_data, bus.d_data},
            {6'd0, 1'b1, 1'b0, 16'h5A3C, 8'hBE});
        cyc();
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("b2b_i1_dhold", {6'd0, bus.i_valid, bus.d_valid, bus.i_data, bus.d_data},
            {6'd0, 1'b1, 1'b0, 16'hCAFE, 8'hBE});
        repeat (2) cyc();

        // 6: reset while a fetch is in flight
        bus.i_req  = 1'b1;
        bus.i_addr = 10'h005;
        @(negedge clk);
        chk("midrst_gnt", {31'd0, bus.i_gnt}, 32'd1);
        #1;
        rst_n     = 1'b0;
        bus.i_req = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_dropped", {14'd0, bus.i_valid, bus.d_valid, bus.i_data}, 32'd0);
        cyc();
        bus.i_req  = 1'b1;
        bus.i_addr = 10'h007;
        cyc();
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("midrst_resume", {15'd0, bus.i_valid, bus.i_data}, {15'd0, 1'b1, 16'hCAFE});
        repeat (3) cyc();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
